// File: rtl/m_wb_uart_pkg.sv
// m_wb_uart_pkg: shared definitions for the Wishbone UART.
// Holds the register offsets, STATUS bit positions and the TX/RX state encodings.
package m_wb_uart_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;

  localparam int unsigned STAT_TXEMPTY = 0;
  localparam int unsigned STAT_RXVALID = 1;
  localparam int unsigned STAT_FERR    = 2;
  localparam int unsigned STAT_OVR     = 3;
  localparam int unsigned STAT_TXIDLE  = 4;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

endpackage

// File: rtl/m_wb_uart_if.sv
// m_wb_uart_if: Wishbone classic-cycle bus bundle between the core and the UART.
//   STB_I  strobe (already qualified by CYC and address decode)
//   WE_I   write enable
//   ADR_I  register select
//   DAT_I  write data, DAT_O read data
//   ACK_O  acknowledge
interface m_wb_uart_if;
  logic        STB_I;
  logic        WE_I;
  logic [1:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/m_wb_uart_rx.sv
// m_wb_uart_rx: 8N1 serial receiver.
//   CLK_I, RST_I  clock, asynchronous active-low reset
//   rxd           asynchronous serial input
//   rx_byte       last assembled byte, valid while byte_done is high
//   byte_done     one-cycle strobe: a frame with a good stop bit arrived
//   ferr_set      one-cycle strobe: a frame ended with stop bit 0
module m_wb_uart_rx
  import m_wb_uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 104,
  parameter int unsigned DIVW    = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       ferr_set
);
  localparam logic [DIVW-1:0] BitLast  = DIVW'(DIVISOR - 1);
  localparam logic [DIVW-1:0] HalfLast = DIVW'(DIVISOR / 2 - 1);

  logic [1:0]      sync_q;
  logic            rxs;
  logic            rxs_prev_q;
  rx_state_e       state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;

  assign rxs     = sync_q[1];
  assign rx_byte = shift_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (rxs_prev_q && !rxs) begin
          cnt_d   = HalfLast;
          state_d = RxStart;
        end
      end
      RxStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else if (rxs) begin
          state_d = RxIdle;  // too short to be a start bit
        end else begin
          cnt_d   = BitLast;
          idx_d   = '0;
          state_d = RxData;
        end
      end
      RxData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = BitLast;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else if (rxs) begin
          byte_done = 1'b1;
          state_d   = RxIdle;
        end else begin
          ferr_set = 1'b1;
          state_d  = RxWaitHigh;
        end
      end
      RxWaitHigh: begin
        // Line may sit low (break); only rearm once it has returned high.
        if (rxs) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

endmodule

// File: rtl/m_wb_uart.sv
// m_wb_uart: Wishbone classic-cycle responder UART (8N1, full duplex).
//   CLK_I, RST_I  clock, asynchronous active-low reset
//   wb            Wishbone slave: ADR 0 DATA, 1 STATUS, 2..3 read zero
//   rxd           serial input, txd serial output (idle high)
//   irq           high while a received byte waits or the TX holding register is free
module m_wb_uart
  import m_wb_uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 104,
  parameter int unsigned DIVW    = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  m_wb_uart_if.slave wb,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  localparam logic [DIVW-1:0] BitLast = DIVW'(DIVISOR - 1);

  logic            ack_q;
  logic [31:0]     dat_q, dat_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  tx_state_e       tx_state_q, tx_state_d;
  logic [DIVW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rxvalid_q, rxvalid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic        accept, rd_rx, wr_tx, wr_stat, txidle, take_hold;
  logic        byte_done, ferr_set, overrun;
  logic [7:0]  rx_byte;
  logic [31:0] rd_data;
  logic        unused_dat;

  assign unused_dat = ^wb.DAT_I[31:8];

  m_wb_uart_rx #(
    .DIVISOR(DIVISOR),
    .DIVW   (DIVW)
  ) u_rx (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .ferr_set (ferr_set)
  );

  // Bus decode and read mux
  always_comb begin
    accept  = wb.STB_I & ~ack_q;
    rd_rx   = accept & ~wb.WE_I & (wb.ADR_I == UART_DATA);
    wr_tx   = accept & wb.WE_I & (wb.ADR_I == UART_DATA);
    wr_stat = accept & wb.WE_I & (wb.ADR_I == UART_STATUS);
    txidle  = (tx_state_q == TxIdle) & ~hold_full_q;
    rd_data = '0;
    case (wb.ADR_I)
      UART_DATA: rd_data[7:0] = rx_data_q;
      UART_STATUS: begin
        rd_data[STAT_TXEMPTY] = ~hold_full_q;
        rd_data[STAT_RXVALID] = rxvalid_q;
        rd_data[STAT_FERR]    = ferr_q;
        rd_data[STAT_OVR]     = ovr_q;
        rd_data[STAT_TXIDLE]  = txidle;
      end
      default: ;
    endcase
    dat_d = (accept & ~wb.WE_I) ? rd_data : '0;
  end

  // TX shifter FSM and holding register
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    take_hold  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (hold_full_q) begin
          take_hold  = 1'b1;
          tx_shift_d = hold_q;
          txd_d      = 1'b0;
          tx_cnt_d   = BitLast;
          tx_state_d = TxStart;
        end
      end
      TxStart, TxData: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - DIVW'(1);
        end else begin
          tx_cnt_d = BitLast;
          if (tx_state_q == TxData && tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TxStop;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_idx_d   = (tx_state_q == TxStart) ? 3'd0 : tx_idx_q + 3'd1;
            tx_state_d = TxData;
          end
        end
      end
      TxStop: begin
        if (tx_cnt_q != '0) begin
          tx_cnt_d = tx_cnt_q - DIVW'(1);
        end else if (hold_full_q) begin
          // Back-to-back: next start bit follows the stop bit with no gap.
          take_hold  = 1'b1;
          tx_shift_d = hold_q;
          txd_d      = 1'b0;
          tx_cnt_d   = BitLast;
          tx_state_d = TxStart;
        end else begin
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (take_hold) hold_full_d = 1'b0;
    if (wr_tx && !hold_full_q) begin
      hold_d      = wb.DAT_I[7:0];
      hold_full_d = 1'b1;
    end
  end

  // RX register and sticky flags; a read on the delivery edge frees the slot.
  always_comb begin
    overrun   = byte_done & rxvalid_q & ~rd_rx;
    rx_data_d = rx_data_q;
    rxvalid_d = rxvalid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    if (rd_rx) rxvalid_d = 1'b0;
    if (byte_done && !overrun) begin
      rx_data_d = rx_byte;
      rxvalid_d = 1'b1;
    end
    if (wr_stat && wb.DAT_I[STAT_FERR]) ferr_d = 1'b0;
    if (wr_stat && wb.DAT_I[STAT_OVR]) ovr_d = 1'b0;
    if (ferr_set) ferr_d = 1'b1;
    if (overrun) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
      rx_data_q   <= '0;
      rxvalid_q   <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ack_q       <= accept;
      dat_q       <= dat_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      rx_data_q   <= rx_data_d;
      rxvalid_q   <= rxvalid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = dat_q;
  assign txd      = txd_q;
  assign irq      = rxvalid_q | ~hold_full_q;

endmodule

// File: doc/m_wb_uart.md
Name: m_wb_uart

Overview:
- Wishbone classic-cycle responder UART for the midgetv core. Replaces the bit-banged usartTX/usartRX pins in the max_upduino2 top.
- Core is the initiator. This block is the responder: it decodes the register offset, returns ACK_O/DAT_O, and runs a full-duplex 8N1 serial transmitter and receiver.
- Sits on the IO address region; the top gates STB_I with the IO-region address decode.

Parameters:
- DIVISOR, 104: CLK_I cycles per bit; 12 MHz / 115200 ≈ 104. Legal range 4..65535.
- DIVW, 16: width of the bit-time counters; must hold DIVISOR-1.

Ports:
- CLK_I  in  1  system clock, all state on rising edge.
- RST_I  in  1  asynchronous active-low reset (0 = reset).
- STB_I  in  1  Wishbone strobe, already qualified by CYC and IO-region decode.
- WE_I   in  1  write enable.
- ADR_I  in  2  register select, driven from core ADR_O[3:2].
- DAT_I  in  32  write data; only [7:0] used.
- DAT_O  out  32  read data; [31:8] always 0.
- ACK_O  out  1  Wishbone acknowledge.
- rxd    in  1  asynchronous serial input.
- txd    out  1  serial output, idle high.
- irq    out  1  high while rxvalid=1 or txempty=1; intended for meip.

Behaviour:
- Reset values: ACK_O=0, DAT_O=0, txd=1, irq=1 (txempty=1). Internally rxvalid=0, ferr=0, ovr=0, both FSMs IDLE.
- Bus acceptance: a transaction is accepted on the edge where STB_I=1 and ACK_O=0.
  - ACK_O=1 on the following cycle for exactly one cycle, then 0, even if STB_I stays high.
  - Every accepted transaction is acked; latency is 1.
  - All side effects happen at the acceptance edge. DAT_O is registered and valid while ACK_O=1, and is 0 otherwise.
- Register map (ADR_I):
  - 0 DATA. Write: load TX holding register with DAT_I[7:0]; ignored if the holding register is full. Read: RX byte in [7:0]; clears rxvalid.
  - 1 STATUS. Read: [0]=txempty (holding free), [1]=rxvalid, [2]=ferr, [3]=ovr, [4]=txidle (shifter idle and holding free). Write: 1 in bit 2 clears ferr, 1 in bit 3 clears ovr (write-1-to-clear).
  - 2, 3: reads return 0, writes ignored, still acked.
- TX FSM (IDLE, START, DATA, STOP), one bit counter and a 3-bit index:
  - IDLE: if the holding register is full, move it into the shifter, mark holding empty, txd=0, go START.
  - START, DATA, STOP each hold txd for DIVISOR cycles. DATA sends 8 bits LSB first. STOP drives txd=1.
  - At the end of STOP: if holding is full, go straight to START (no idle gap, back-to-back); else go IDLE.
  - A write accepted while the shifter is busy fills holding, so two bytes can be outstanding.
- RX (sub-module):
  - rxd passes through a 2-FF synchroniser.
  - IDLE: a synchronised 1→0 transition goes to START.
  - START: wait DIVISOR/2 (integer) cycles, resample. If 1, treat as a glitch and return to IDLE with no flags. If 0, go DATA.
  - DATA: 8 samples, each DIVISOR cycles apart, LSB first.
  - STOP: sample once more. If 1, deliver the byte. If 0, set ferr, discard the byte, and wait for synchronised rxd=1 before re-entering IDLE.
- Delivery when rxvalid=0: load the RX register, set rxvalid. When rxvalid=1: set ovr, keep the old byte.
- Simultaneous events:
  - A DATA read and a new-byte delivery on the same edge: the read returns the old byte, rxvalid stays 1 with the new byte loaded, no ovr.
  - A status W1C and an error set on the same edge: the set wins.
- Reset mid-frame: txd returns to 1 immediately (asynchronous), the frame is aborted and holding is emptied. RX returns to IDLE. A partially received byte is discarded.

Decomposition:
- Shared package/header holds: register offsets (UART_DATA=0, UART_STATUS=1), STATUS bit indices, TX/RX state encodings.
- One natural sub-module: m_wb_uart_rx, containing the synchroniser, RX FSM and sampling counter. It outputs a byte, a byte_done strobe and a ferr_set strobe.
- TX, the register file and the Wishbone logic stay in m_wb_uart.

Test Plan (DIVISOR=4):
- Reset/idle: hold RST_I=0 then release → txd=1, ACK_O=0, STATUS read = 0x11, irq=1.
- Ack protocol: STB_I held high 5 cycles on STATUS → ACK_O pattern 0,1,0,1,0. DAT_O=0 whenever ACK_O=0.
- TX frame: write DATA=0x55 → txd low from 2nd edge after acceptance. Sequence 0,1,0,1,0,1,0,1,0,1, each 4 cycles. Then txd=1 and STATUS[4]=1.
- TX back-to-back: write 0xA5 then 0x3C immediately, then a third write while both are outstanding → the third is ignored. 20 bit-times of frames with no idle gap between stop and start.
- RX byte, then overrun: drive frame 0xC3 on rxd → rxvalid=1, irq=1, DATA read = 0xC3, rxvalid=0. Drive two frames without a read → ovr=1, DATA read = first byte.
- RX errors: a 1-cycle low glitch on rxd → no flags. A frame with stop=0 → ferr=1 and rxvalid unchanged. Write STATUS=0x04 → ferr=0.
